cpu_run_monitor: RTL and testbench

//  Synthesizable run monitor for the single-cycle CPU.

---
 rtl/cpu_run_monitor.sv | 135 +++++++++++++
 tb/tb_cpu_run_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Run monitor beside the single-cycle CPU: checkpoints, end sentinel, watchdog, counters.
// Latency: all outputs registered; done/pass/timeout appear the cycle after the deciding edge. No backpressure.
module cpu_run_monitor #(
    parameter int          NUM_CHECKS   = 4,
    parameter int          MAX_CYCLES   = 20,
    parameter int          CNT_WIDTH    = 32,
    parameter logic [31:0] END_SENTINEL = 32'h0000_006F,
    localparam int         IDX_W        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic                  cfg_kind,
    input  logic [31:0]           cfg_addr,
    input  logic [31:0]           cfg_data,
    input  logic                  cfg_en,
    input  logic                  start,
    input  logic                  retire_valid,
    input  logic [31:0]           retire_pc,
    input  logic [31:0]           retire_instr,
    input  logic                  rf_we,
    input  logic [4:0]            rf_waddr,
    input  logic [31:0]           rf_wdata,
    input  logic                  mem_we,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [NUM_CHECKS-1:0] checks_met,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [CNT_WIDTH-1:0]  instr_count,
    output logic [7:0]            misaligned_count,
    output logic [31:0]           end_pc
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [NUM_CHECKS-1:0] slot_en, slot_kind;
    logic [31:0]           slot_addr [NUM_CHECKS];
    logic [31:0]           slot_data [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] hit, met_nxt;
    logic                  sentinel, wd_expire, run_start, idx_ok;

    assign sentinel  = retire_valid && (retire_instr == END_SENTINEL);
    assign wd_expire = (cycle_count == CNT_WIDTH'(MAX_CYCLES - 1));
    assign run_start = start && (state == S_IDLE || state == S_DONE);
    assign idx_ok    = ({1'b0, cfg_idx} < (IDX_W + 1)'(NUM_CHECKS));
    assign busy      = (state == S_RUN);

    // x0 writes never count as a register hit
    always_comb begin
        hit = '0;
        for (int s = 0; s < NUM_CHECKS; s++) begin
            if (slot_en[s]) begin
                if (!slot_kind[s])
                    hit[s] = rf_we && (rf_waddr == slot_addr[s][4:0]) &&
                             (rf_wdata == slot_data[s]) && (slot_addr[s][4:0] != 5'd0);
                else
                    hit[s] = mem_we && (mem_addr == slot_addr[s]) && (mem_wdata == slot_data[s]);
            end
        end
        met_nxt = checks_met | hit;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (sentinel || wd_expire) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            slot_en          <= '0;
            slot_kind        <= '0;
            for (int s = 0; s < NUM_CHECKS; s++) begin
                slot_addr[s] <= '0;
                slot_data[s] <= '0;
            end
            done             <= 1'b0;
            pass             <= 1'b0;
            timeout          <= 1'b0;
            checks_met       <= '0;
            cycle_count      <= '0;
            instr_count      <= '0;
            misaligned_count <= '0;
            end_pc           <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && cfg_we && idx_ok) begin
                slot_en[cfg_idx]   <= cfg_en;
                slot_kind[cfg_idx] <= cfg_kind;
                slot_addr[cfg_idx] <= cfg_addr;
                slot_data[cfg_idx] <= cfg_data;
            end
            if (run_start) begin
                done             <= 1'b0;
                pass             <= 1'b0;
                timeout          <= 1'b0;
                checks_met       <= '0;
                cycle_count      <= '0;
                instr_count      <= '0;
                misaligned_count <= '0;
                end_pc           <= '0;
            end else if (state == S_RUN) begin
                if (cycle_count != '1)
                    cycle_count <= cycle_count + 1'b1;
                instr_count <= instr_count + CNT_WIDTH'(retire_valid);
                checks_met  <= met_nxt;
                if (mem_we && (mem_addr[1:0] != 2'b00) && (misaligned_count != 8'hFF))
                    misaligned_count <= misaligned_count + 8'd1;
                // sentinel takes priority over a coincident watchdog expiry
                if (sentinel) begin
                    done    <= 1'b1;
                    end_pc  <= retire_pc;
                    pass    <= &(met_nxt | ~slot_en);
                    timeout <= 1'b0;
                end else if (wd_expire) begin
                    done    <= 1'b1;
                    timeout <= 1'b1;
                    pass    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized and directed runs of cpu_run_monitor against a per-run outcome model.
module tb_cpu_run_monitor;
    localparam int          NC   = 4;
    localparam int          MAXC = 20;
    localparam logic [31:0] SENT = 32'h0000_006F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n = 1'b0;
    logic          cfg_we = 1'b0, cfg_kind = 1'b0, cfg_en = 1'b0, start = 1'b0;
    logic [1:0]    cfg_idx = '0;
    logic [31:0]   cfg_addr = '0, cfg_data = '0;
    logic          retire_valid = 1'b0, rf_we = 1'b0, mem_we = 1'b0;
    logic [31:0]   retire_pc = '0, retire_instr = '0, rf_wdata = '0, mem_addr = '0, mem_wdata = '0;
    logic [4:0]    rf_waddr = '0;
    logic          busy, done, pass, timeout;
    logic [NC-1:0] checks_met;
    logic [31:0]   cycle_count, instr_count, end_pc;
    logic [7:0]    misaligned_count;

    cpu_run_monitor dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_kind(cfg_kind),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_en(cfg_en), .start(start),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .checks_met(checks_met),
        .cycle_count(cycle_count), .instr_count(instr_count),
        .misaligned_count(misaligned_count), .end_pc(end_pc)
    );

    typedef struct {
        logic rv; logic [31:0] pc, ins;
        logic rfwe; logic [4:0] rfa; logic [31:0] rfd;
        logic mwe; logic [31:0] ma, md;
        logic cwe; logic [1:0] cidx; logic ckind, cen; logic [31:0] caddr, cdata;
        logic st;
    } cyc_t;

    cyc_t        stim [64];
    int          slen;
    logic        m_kind [NC];
    logic        m_en   [NC];
    logic [31:0] m_addr [NC];
    logic [31:0] m_data [NC];

    int          n_chk = 0, n_pass = 0;
    int          e_cyc, e_instr, e_mis;
    logic        e_sent, e_pass;
    logic [NC-1:0] e_met;
    logic [31:0] e_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        reset_n = 1'b1;
        start   = 1'b0;
        for (int s = 0; s < NC; s++) begin
            m_kind[s] = 1'b0; m_en[s] = 1'b0; m_addr[s] = '0; m_data[s] = '0;
        end
    endtask

    task automatic cfg_write(input int idx, input logic kind, input logic [31:0] addr,
                             input logic [31:0] data, input logic en);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_kind = kind;
        cfg_addr = addr; cfg_data = data; cfg_en = en;
        tick();
        cfg_we = 1'b0;
        m_kind[idx] = kind; m_addr[idx] = addr; m_data[idx] = data; m_en[idx] = en;
    endtask

    task automatic clear_stim(input int n);
        slen = n;
        for (int i = 0; i < 64; i++) begin
            stim[i] = '{rv: 1'b1, pc: 32'(4 * i), ins: 32'h0000_0013, rfwe: 1'b0, rfa: '0,
                        rfd: '0, mwe: 1'b0, ma: '0, md: '0, cwe: 1'b0, cidx: '0, ckind: 1'b0,
                        cen: 1'b0, caddr: '0, cdata: '0, st: 1'b0};
        end
    endtask

    // Outcome of one run, from the checkpoint/sentinel/watchdog rules over the whole trace
    task automatic model_run();
        e_cyc = MAXC; e_sent = 1'b0;
        for (int i = 0; i < slen && i < MAXC; i++)
            if (stim[i].rv && stim[i].ins == SENT) begin
                e_cyc = i + 1; e_sent = 1'b1; break;
            end
        e_instr = 0; e_mis = 0; e_met = '0;
        for (int i = 0; i < e_cyc; i++) begin
            e_instr += int'(stim[i].rv);
            if (stim[i].mwe && stim[i].ma[1:0] != 2'b00 && e_mis < 255) e_mis++;
            for (int s = 0; s < NC; s++) begin
                if (!m_en[s]) continue;
                if (!m_kind[s] && stim[i].rfwe && m_addr[s][4:0] != 0 &&
                    stim[i].rfa == m_addr[s][4:0] && stim[i].rfd == m_data[s]) e_met[s] = 1'b1;
                if (m_kind[s] && stim[i].mwe && stim[i].ma == m_addr[s] &&
                    stim[i].md == m_data[s]) e_met[s] = 1'b1;
            end
        end
        e_pass = e_sent;
        for (int s = 0; s < NC; s++) if (m_en[s] && !e_met[s]) e_pass = 1'b0;
        e_pc = e_sent ? stim[e_cyc-1].pc : 32'h0;
        // start is only legal while still running, otherwise it would relaunch
        for (int i = e_cyc; i < 64; i++) stim[i].st = 1'b0;
    endtask

    task automatic run_stim(input string nm);
        model_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, ".busy_start"}, 64'(busy), 64'd1);
        chk({nm, ".done_start"}, 64'(done), 64'd0);
        for (int i = 0; i < slen; i++) begin
            retire_valid = stim[i].rv; retire_pc = stim[i].pc; retire_instr = stim[i].ins;
            rf_we = stim[i].rfwe; rf_waddr = stim[i].rfa; rf_wdata = stim[i].rfd;
            mem_we = stim[i].mwe; mem_addr = stim[i].ma; mem_wdata = stim[i].md;
            cfg_we = stim[i].cwe; cfg_idx = stim[i].cidx; cfg_kind = stim[i].ckind;
            cfg_en = stim[i].cen; cfg_addr = stim[i].caddr; cfg_data = stim[i].cdata;
            start = stim[i].st;
            tick();
        end
        {retire_valid, rf_we, mem_we, cfg_we, start} = '0;
        chk({nm, ".busy"}, 64'(busy), 64'd0);
        chk({nm, ".done"}, 64'(done), 64'd1);
        chk({nm, ".pass"}, 64'(pass), 64'(e_pass));
        chk({nm, ".timeout"}, 64'(timeout), 64'(!e_sent));
        chk({nm, ".checks_met"}, 64'(checks_met), 64'(e_met));
        chk({nm, ".cycle_count"}, 64'(cycle_count), 64'(e_cyc));
        chk({nm, ".instr_count"}, 64'(instr_count), 64'(e_instr));
        chk({nm, ".misaligned"}, 64'(misaligned_count), 64'(e_mis));
        chk({nm, ".end_pc"}, 64'(end_pc), 64'(e_pc));
    endtask

    function automatic logic [31:0] pick(input logic [31:0] a, b, c, d);
        case ($urandom_range(0, 3))
            0: return a;
            1: return b;
            2: return c;
            default: return d;
        endcase
    endfunction

    task automatic gen_random();
        clear_stim($urandom_range(MAXC + 2, 30));
        for (int i = 0; i < slen; i++) begin
            stim[i].rv    = ($urandom_range(0, 3) != 0);
            stim[i].pc    = {$urandom_range(0, 255), 2'b00};
            stim[i].ins   = ($urandom_range(0, 9) == 0) ? SENT : $urandom();
            stim[i].rfwe  = $urandom_range(0, 1);
            stim[i].rfa   = 5'(pick(0, 1, 2, 6));
            stim[i].rfd   = pick(5, 32'h10, 32'h11, 32'h10);
            stim[i].mwe   = ($urandom_range(0, 2) == 0);
            stim[i].ma    = pick(32'h40, 32'h42, 32'h44, 32'h41);
            stim[i].md    = pick(5, 32'h10, 32'h11, 32'hDEADBEEF);
            stim[i].cwe   = ($urandom_range(0, 3) == 0);
            stim[i].cidx  = 2'($urandom_range(0, 3));
            stim[i].ckind = $urandom_range(0, 1);
            stim[i].cen   = 1'b1;
            stim[i].caddr = pick(1, 2, 6, 32'h44);
            stim[i].cdata = pick(5, 32'h10, 32'h11, 32'hDEADBEEF);
            stim[i].st    = ($urandom_range(0, 5) == 0);
        end
    endtask

    task automatic random_cfg();
        for (int s = 0; s < NC; s++) begin
            logic k;
            k = $urandom_range(0, 1);
            cfg_write(s, k, k ? pick(32'h40, 32'h42, 32'h44, 32'h41) : pick(0, 1, 2, 6),
                      pick(5, 32'h10, 32'h11, 32'hDEADBEEF), ($urandom_range(0, 2) != 0));
        end
    endtask

    initial begin
        // reset held with start asserted
        start = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst.busy", 64'(busy), 0);
        chk("rst.done", 64'(done), 0);
        chk("rst.pass", 64'(pass), 0);
        chk("rst.timeout", 64'(timeout), 0);
        chk("rst.cycle_count", 64'(cycle_count), 0);
        chk("rst.instr_count", 64'(instr_count), 0);
        chk("rst.checks_met", 64'(checks_met), 0);
        do_reset(1);

        // reg + mem checkpoint, sentinel at PC 0x20 on cycle 8
        cfg_write(0, 1'b0, 32'd6, 32'h10, 1'b1);
        cfg_write(1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1);
        clear_stim(12);
        stim[3].rfwe = 1'b1; stim[3].rfa = 5'd6; stim[3].rfd = 32'h10;
        stim[5].mwe = 1'b1; stim[5].ma = 32'h40; stim[5].md = 32'hDEADBEEF;
        stim[8].ins = SENT;
        run_stim("basic");
        chk("basic.met_const", 64'(checks_met), 64'h3);
        chk("basic.cyc_const", 64'(cycle_count), 64'd9);
        chk("basic.pc_const", 64'(end_pc), 64'h20);

        // rerun from DONE, config kept, no sentinel
        clear_stim(25);
        stim[3].rfwe = 1'b1; stim[3].rfa = 5'd6; stim[3].rfd = 32'h10;
        run_stim("wdog");
        chk("wdog.timeout_const", 64'(timeout), 64'd1);
        chk("wdog.cyc_const", 64'(cycle_count), 64'd20);

        // wrong value and x0 slot never hit
        do_reset(2);
        cfg_write(0, 1'b0, 32'd6, 32'h10, 1'b1);
        cfg_write(1, 1'b0, 32'd0, 32'd5, 1'b1);
        clear_stim(8);
        stim[1].rfwe = 1'b1; stim[1].rfa = 5'd6; stim[1].rfd = 32'h11;
        stim[2].rfwe = 1'b1; stim[2].rfa = 5'd0; stim[2].rfd = 32'd5;
        stim[4].ins = SENT;
        run_stim("nohit");
        chk("nohit.pass_const", 64'(pass), 64'd0);

        // misaligned store still hits; sentinel on the final watchdog cycle wins
        do_reset(2);
        cfg_write(2, 1'b1, 32'h42, 32'd7, 1'b1);
        clear_stim(24);
        stim[6].mwe = 1'b1; stim[6].ma = 32'h42; stim[6].md = 32'd7;
        stim[19].ins = SENT;
        run_stim("edge");
        chk("edge.mis_const", 64'(misaligned_count), 64'd1);
        chk("edge.pass_const", 64'(pass), 64'd1);
        chk("edge.timeout_const", 64'(timeout), 64'd0);

        // reset mid-run clears state and configuration
        cfg_write(0, 1'b0, 32'd1, 32'd1, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        retire_valid = 1'b1; mem_we = 1'b1; mem_addr = 32'h41;
        tick(); tick(); tick();
        {retire_valid, mem_we} = '0;
        reset_n = 1'b0; tick();
        chk("midrst.busy", 64'(busy), 0);
        chk("midrst.cycle_count", 64'(cycle_count), 0);
        chk("midrst.instr_count", 64'(instr_count), 0);
        chk("midrst.misaligned", 64'(misaligned_count), 0);
        do_reset(1);

        // cfg writes during RUN are ignored; zero enabled slots passes
        clear_stim(6);
        stim[0].cwe = 1'b1; stim[0].cidx = 2'd0; stim[0].caddr = 32'd1; stim[0].cdata = 32'd1;
        stim[0].cen = 1'b1;
        stim[1].rfwe = 1'b1; stim[1].rfa = 5'd1; stim[1].rfd = 32'd1;
        stim[2].ins = SENT;
        run_stim("cfgrun");

        for (int r = 0; r < 16; r++) begin
            if (r % 4 == 0) begin
                do_reset(1);
                random_cfg();
            end
            gen_random();
            run_stim($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
